window_scan_ctrl: RTL

WINDOW_SCAN_CTRL -- requirements
Module: window_scan_ctrl

---
 rtl/window_scan_ctrl_if.sv | 17 +
 rtl/window_scan_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/window_scan_ctrl_if.sv
// Pixel-fetch bus between the window scan controller and pixel memory.
//
// Handshake: the master raises mem_req with a valid mem_addr and holds both
// stable until the slave answers with a one-cycle mem_ack.  A cycle with
// mem_req=1 and mem_ack=1 transfers exactly one pixel, and pixel data is
// valid in that same cycle.  The master may raise the next request in the
// cycle straight after an acknowledge.  mem_ack while mem_req=0 means nothing.
interface window_scan_ctrl_if #(
  parameter int AW = 8
) ();
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;

  modport master (output mem_req, output mem_addr, input mem_ack);
  modport slave  (input mem_req, input mem_addr, output mem_ack);
endinterface

// File: rtl/window_scan_ctrl.sv
// Raster-order window scan controller.
// Reads a frame pixel by pixel in row-major order and issues the shift/clear
// strobes that feed a WIN-deep sliding-window datapath.
module window_scan_ctrl #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  parameter int WIN   = 5,
  parameter int AW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  window_scan_ctrl_if.master  mem,
  output logic                shift_en,
  output logic                row_end,
  output logic                win_valid,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FW = $clog2(WIN + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_ROWEND = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(WIN);
  localparam logic [FW-1:0] FILL_THR = FW'(WIN - 1);

  logic [1:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [FW-1:0] fill;
  // Linear pixel index; equals row*IMG_W+col because the scan is row-major.
  logic [AW-1:0] pix;
  logic          ack_ok;

  // An acknowledge only counts while a request is actually outstanding.
  assign ack_ok = (state == S_FETCH) && mem.mem_ack;

  // Scan sequencer: state, column/row position and linear address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      col   <= '0;
      row   <= '0;
      pix   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            col   <= '0;
            row   <= '0;
            pix   <= '0;
          end
        end
        S_FETCH: begin
          if (ack_ok) begin
            pix <= pix + AW'(1);
            if (col == COL_LAST) begin
              state <= S_ROWEND;
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        S_ROWEND: begin
          col <= '0;
          if (row == ROW_LAST) begin
            state <= S_DONE;
          end else begin
            row   <= row + RW'(1);
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Per-row window fill count; ROWEND always lasts one cycle, so clearing
  // there restarts the count before the next row's first shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill <= '0;
    end else if (state == S_ROWEND) begin
      fill <= '0;
    end else if ((state == S_IDLE) && start) begin
      fill <= '0;
    end else if (shift_en && (fill != FILL_MAX)) begin
      fill <= fill + FW'(1);
    end
  end

  // Registered strobes: shift one cycle after ack, row/frame end one cycle
  // after ROWEND so they never overlap the last shift of the row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_en <= 1'b0;
      row_end  <= 1'b0;
      done     <= 1'b0;
    end else begin
      shift_en <= ack_ok;
      row_end  <= (state == S_ROWEND);
      done     <= (state == S_ROWEND) && (row == ROW_LAST);
    end
  end

  // Output decode; all terms come from registers, so reset clears them at once.
  always_comb begin
    mem.mem_req  = (state == S_FETCH);
    mem.mem_addr = (state == S_FETCH) ? pix : '0;
    busy         = (state != S_IDLE);
    win_valid    = shift_en && (fill >= FILL_THR);
    state_dbg    = state;
  end

endmodule
